otter_alu_arbiter: RTL and testbench

- Shares one OTTER_ALU instance between two requesters, e.g. the EX stage and an auxiliary address/branch unit.
- Arbitration between requesters is round-robin.
- Both sides use a valid/ready handshake.
- The ALU output is registered into a single-entry result buffer; the response is routed back to the requester whose request was granted.

---
 rtl/otter_alu_pkg.sv | 23 ++
 rtl/otter_alu.sv | 38 +++
 rtl/otter_alu_arbiter.sv | 115 +++++++++++
 tb/tb_otter_alu_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_alu_pkg.sv
// Shared ALU definitions: op-code encoding ({func7[5], func3}) and datapath widths.
package otter_alu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 4;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [OP_W-1:0] {
        ADD  = 4'd0,
        SLL  = 4'd1,
        SLT  = 4'd2,
        SLTU = 4'd3,
        XOR  = 4'd4,
        SRL  = 4'd5,
        OR   = 4'd6,
        AND  = 4'd7,
        SUB  = 4'd8,
        LUI  = 4'd9,
        MUL  = 4'd10,
        SRA  = 4'd13
    } alu_op_t;

endpackage

// File: rtl/otter_alu.sv
// OTTER ALU: purely combinational, result valid in the same cycle as its inputs.
//   op_i     : operation code ({func7[5], func3}); undefined codes yield 0
//   a_i, b_i : operands (shift amount taken from b_i[4:0])
//   result_o : operation result (low XLEN bits for multiply)
module otter_alu
    import otter_alu_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o
);

    logic [SHAMT_W-1:0] shamt;

    assign shamt = b_i[SHAMT_W-1:0];

    // Operation decode
    always_comb begin
        result_o = '0;
        case (alu_op_t'(op_i))
            ADD:  result_o = a_i + b_i;
            SUB:  result_o = a_i - b_i;
            OR:   result_o = a_i | b_i;
            AND:  result_o = a_i & b_i;
            XOR:  result_o = a_i ^ b_i;
            SRL:  result_o = a_i >> shamt;
            SLL:  result_o = a_i << shamt;
            SRA:  result_o = XLEN'($signed(a_i) >>> shamt);
            SLT:  result_o = XLEN'($signed(a_i) < $signed(b_i));
            SLTU: result_o = XLEN'(a_i < b_i);
            LUI:  result_o = a_i;
            MUL:  result_o = XLEN'(a_i * b_i);
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/otter_alu_arbiter.sv
// Two-requester round-robin front end for a single shared OTTER ALU, with a
// one-entry registered result buffer routed back to the granted requester.
//   CLK, RST            : clock, synchronous active-high reset
//   req<k>_valid/ready  : request handshake (ready is combinational on valid)
//   req<k>_op/_a/_b     : op code and operands
//   rsp<k>_valid/ready  : response handshake
//   rsp<k>_data         : shared result register, meaningful only with valid
//   busy                : result buffer occupied
module otter_alu_arbiter
    import otter_alu_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [OP_W-1:0] req0_op,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [OP_W-1:0] req1_op,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_data,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_data,
    output logic            busy
);

    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_owner_q, rsp_owner_d;
    logic [XLEN-1:0] rsp_data_q,  rsp_data_d;
    logic            last_grant_q, last_grant_d;

    logic            grant;
    logic            grant_vld;
    logic            drain;
    logic            can_accept;
    logic            accept;
    logic [OP_W-1:0] alu_op;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_y;

    // Round-robin grant: on conflict, favour the requester not served last
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant     = req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end
    end

    // Buffer frees up in the same cycle its owner consumes it (pass-through)
    assign drain      = rsp_valid_q && (rsp_owner_q ? rsp1_ready : rsp0_ready);
    assign can_accept = !rsp_valid_q || drain;
    // Nothing is accepted while reset is asserted
    assign accept     = grant_vld && can_accept && !RST;

    assign req0_ready = accept && !grant;
    assign req1_ready = accept &&  grant;

    // Operand mux into the single shared ALU
    assign alu_op = grant ? req1_op : req0_op;
    assign alu_a  = grant ? req1_a  : req0_a;
    assign alu_b  = grant ? req1_b  : req0_b;

    otter_alu u_alu (
        .op_i     (alu_op),
        .a_i      (alu_a),
        .b_i      (alu_b),
        .result_o (alu_y)
    );

    // Result buffer and grant pointer next state
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_owner_d  = rsp_owner_q;
        rsp_data_d   = rsp_data_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            rsp_valid_d  = 1'b1;
            rsp_owner_d  = grant;
            rsp_data_d   = alu_y;
            last_grant_d = grant;
        end else if (drain) begin
            rsp_valid_d  = 1'b0;
        end
    end

    // State registers; pointer resets to 1 so requester 0 wins the first conflict
    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_valid_q  <= 1'b0;
            rsp_owner_q  <= 1'b0;
            rsp_data_q   <= '0;
            last_grant_q <= 1'b1;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_owner_q  <= rsp_owner_d;
            rsp_data_q   <= rsp_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp0_valid = rsp_valid_q && !rsp_owner_q;
    assign rsp1_valid = rsp_valid_q &&  rsp_owner_q;
    assign rsp0_data  = rsp_data_q;
    assign rsp1_data  = rsp_data_q;
    assign busy       = rsp_valid_q;

endmodule

// File: tb/tb_otter_alu_arbiter.sv
// Self-checking bench for otter_alu_arbiter: directed scenarios plus randomized
// traffic, checked against a transaction-level reference model.
module tb_otter_alu_arbiter;
    import otter_alu_pkg::*;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            req0_valid, req0_ready, req1_valid, req1_ready;
    logic [OP_W-1:0] req0_op, req1_op;
    logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
    logic            rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [XLEN-1:0] rsp0_data, rsp1_data;
    logic            busy;

    otter_alu_arbiter dut (
        .CLK        (CLK),
        .RST        (RST),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Requester agents: a pending op is held until the bench sees it accepted
    logic            p_v  [2];
    logic [OP_W-1:0] p_op [2];
    logic [XLEN-1:0] p_a  [2];
    logic [XLEN-1:0] p_b  [2];
    logic            rr   [2];

    // Reference model: at most one outstanding result, plus whose turn it is on a tie
    logic            m_full;
    int              m_owner;
    logic [XLEN-1:0] m_data;
    int              m_tie_winner;
    int              last_k;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [63:0] prod;
        sh = int'(b % 32);
        case (op)
            4'd0:  return a + b;
            4'd8:  return a + (~b + 32'd1);
            4'd6:  return a | b;
            4'd7:  return a & b;
            4'd4:  return a ^ b;
            4'd5:  return a >> sh;
            4'd1:  return a << sh;
            4'd13: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            4'd2:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd3:  return (a < b) ? 32'd1 : 32'd0;
            4'd9:  return a;
            4'd10: begin prod = {32'd0, a} * {32'd0, b}; return prod[31:0]; end
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_full = 1'b0; m_owner = 0; m_data = '0; m_tie_winner = 0;
    endtask

    // One clock: drive agents, check outputs at the falling edge, advance model
    task automatic step();
        logic consumed, room, acc;
        int k;
        req0_valid = p_v[0]; req0_op = p_op[0]; req0_a = p_a[0]; req0_b = p_b[0];
        req1_valid = p_v[1]; req1_op = p_op[1]; req1_a = p_a[1]; req1_b = p_b[1];
        rsp0_ready = rr[0];  rsp1_ready = rr[1];
        @(negedge CLK);
        consumed = m_full && rr[m_owner];
        room     = !m_full || consumed;
        if (p_v[0] && p_v[1]) k = m_tie_winner;
        else if (p_v[0])      k = 0;
        else if (p_v[1])      k = 1;
        else                  k = -1;
        acc = !RST && room && (k >= 0);
        chk("req0_ready", 32'(req0_ready), 32'(acc && k == 0));
        chk("req1_ready", 32'(req1_ready), 32'(acc && k == 1));
        chk("rsp0_valid", 32'(rsp0_valid), 32'(m_full && m_owner == 0));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(m_full && m_owner == 1));
        chk("busy",       32'(busy),       32'(m_full));
        if (m_full) chk("rsp_data", (m_owner == 0) ? rsp0_data : rsp1_data, m_data);
        last_k = acc ? k : -1;
        if (RST) begin
            model_reset();
        end else if (acc) begin
            m_full = 1'b1; m_owner = k; m_data = alu_ref(p_op[k], p_a[k], p_b[k]);
            m_tie_winner = 1 - k;
        end else if (consumed) begin
            m_full = 1'b0;
        end
        @(posedge CLK);
        #1;
        if (acc) p_v[k] = 1'b0;
    endtask

    task automatic set_req(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        p_v[k] = 1'b1; p_op[k] = op; p_a[k] = a; p_b[k] = b;
    endtask

    task automatic do_reset();
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    typedef struct { logic [3:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] y; } vec_t;
    vec_t vecs [5];
    logic [31:0] held;

    initial begin
        for (int k = 0; k < 2; k++) begin
            p_v[k] = 1'b0; p_op[k] = '0; p_a[k] = '0; p_b[k] = '0; rr[k] = 1'b1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = '0; req1_op = '0; req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        last_k = -1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();

        // Reset state and basic add
        step();
        set_req(0, 4'd0, 32'd5, 32'd3);
        step();
        chk("add_grant", 32'(last_k), 32'd0);
        chk("add_data", rsp0_data, 32'd8);
        chk("add_rsp0_valid", 32'(rsp0_valid), 32'd1);
        chk("add_rsp1_valid", 32'(rsp1_valid), 32'd0);
        step();

        // First conflict after reset goes to requester 0
        do_reset();
        set_req(0, 4'd8, 32'd10, 32'd4);
        set_req(1, 4'd7, 32'h0000_00F0, 32'h0000_003C);
        step();
        chk("conf_first", 32'(last_k), 32'd0);
        chk("conf_sub", rsp0_data, 32'd6);
        step();
        chk("conf_second", 32'(last_k), 32'd1);
        chk("conf_and", rsp1_data, 32'h30);
        step();

        // Round-robin fairness under continuous contention
        do_reset();
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 2; k++)
                if (!p_v[k]) set_req(k, 4'd0, 32'(i), 32'(k));
            step();
            chk("rr_grant", 32'(last_k), 32'(i % 2));
        end
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        step();

        // Backpressure on requester 1's result with requester 0 waiting
        do_reset();
        rr[1] = 1'b0;
        set_req(1, 4'd0, 32'd1, 32'd2);
        step();
        held = rsp1_data;
        set_req(0, 4'd0, 32'd3, 32'd4);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold", rsp1_data, held);
            chk("bp_busy", 32'(busy), 32'd1);
        end
        rr[1] = 1'b1;
        step();
        chk("bp_pass_grant", 32'(last_k), 32'd0);
        chk("bp_pass_data", rsp0_data, 32'd7);
        step();

        // ALU op coverage through requester 1
        vecs[0] = '{4'd13, 32'h8000_0000, 32'd4, 32'hF800_0000};
        vecs[1] = '{4'd2,  32'hFFFF_FFFF, 32'd1, 32'd1};
        vecs[2] = '{4'd3,  32'hFFFF_FFFF, 32'd1, 32'd0};
        vecs[3] = '{4'd10, 32'd7,         32'd6, 32'd42};
        vecs[4] = '{4'd15, 32'h1234_5678, 32'd9, 32'd0};
        for (int i = 0; i < 5; i++) begin
            set_req(1, vecs[i].op, vecs[i].a, vecs[i].b);
            step();
            chk("alu_vec", rsp1_data, vecs[i].y);
        end
        step();

        // Reset while a result is stalled
        do_reset();
        rr[0] = 1'b0;
        set_req(0, 4'd0, 32'd1, 32'd1);
        step();
        step();
        chk("mid_valid_before", 32'(rsp0_valid), 32'd1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("mid_valid_after", 32'(rsp0_valid), 32'd0);
        chk("mid_busy_after", 32'(busy), 32'd0);
        rr[0] = 1'b1;
        set_req(0, 4'd0, 32'd2, 32'd2);
        set_req(1, 4'd0, 32'd3, 32'd3);
        step();
        chk("mid_first_conflict", 32'(last_k), 32'd0);
        step();
        step();

        // Randomized traffic with random backpressure and occasional reset
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!p_v[k] && ($urandom % 3 != 0)) begin
                    set_req(k, 4'($urandom), $urandom,
                            ($urandom % 2 == 0) ? 32'($urandom % 64) : $urandom);
                end
                rr[k] = ($urandom % 4 != 0);
            end
            RST = ($urandom % 250 == 0);
            step();
        end
        RST = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
